// File: rtl/hit_detector_pkg.sv
// hit_detector_pkg
// Shared definitions for the punch-target hit detector: the controller
// state encoding, default parameter values and the saturating increment
// used by the hit/miss tallies.
package hit_detector_pkg;

  // Default parameter values for the detector
  localparam int DEF_N_LANES         = 3;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_CNT_W           = 8;

  // Widest tally the saturating helper can handle
  localparam int MAX_CNT_W = 32;

  typedef enum logic [2:0] {
    S_DETECTING = 3'd0,
    S_DEBOUNCE  = 3'd1,
    S_DETECTED  = 3'd2,
    S_MISSED    = 3'd3,
    S_RELEASE   = 3'd4
  } state_t;

  // Increment that sticks at 'limit' instead of wrapping. Callers widen
  // their tally to MAX_CNT_W and truncate the result back.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(
    input logic [MAX_CNT_W-1:0] value,
    input logic [MAX_CNT_W-1:0] limit
  );
    if (value >= limit) begin
      return limit;
    end
    return value + 1'b1;
  endfunction

endpackage

// File: rtl/hit_detector_lane_prio_enc.sv
// lane_prio_enc
// Lowest-set-bit priority encoder across the button lanes.
// Ports:
//   req   - one request bit per lane
//   idx   - index of the lowest set request bit (0 when none is set)
//   valid - high when at least one request bit is set
module lane_prio_enc #(
  parameter int N = 3,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = W'(i);
      end
    end
  end

endmodule

// File: rtl/hit_detector.sv
// hit_detector
// Debounced hit/miss detector for the punch-target game. A press is
// snapshotted, must stay identical for DEBOUNCE_CYCLES edges, and is then
// classified against the target flags as a hit or a miss. After a
// classification the detector locks out until every button is released.
// Ports:
//   clk, rst     - clock and asynchronous active-high reset
//   enable       - arms detection of a new press
//   clr          - synchronous clear of both tallies (wins over increments)
//   btn          - button levels, one per lane, synchronous to clk
//   mole         - target-present flag per lane
//   shift        - one-cycle pulse on a hit
//   need_random  - one-cycle pulse on a hit, identical to shift
//   miss         - one-cycle pulse on a miss
//   hit_mask     - pressed lanes that had a target at the last hit
//   hit_lane     - lowest index set in hit_mask
//   hit_count    - saturating hit tally
//   miss_count   - saturating miss tally
module hit_detector
  import hit_detector_pkg::*;
#(
  parameter int N_LANES         = DEF_N_LANES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       clr,
  input  logic [N_LANES-1:0]         btn,
  input  logic [N_LANES-1:0]         mole,
  output logic                       shift,
  output logic                       need_random,
  output logic                       miss,
  output logic [N_LANES-1:0]         hit_mask,
  output logic [$clog2(N_LANES)-1:0] hit_lane,
  output logic [CNT_W-1:0]           hit_count,
  output logic [CNT_W-1:0]           miss_count
);

  localparam int LANE_W = $clog2(N_LANES);
  localparam int DBC_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t              state;
  state_t              state_next;
  logic [N_LANES-1:0]  snap;
  logic [N_LANES-1:0]  eval_mask;
  logic [DBC_W-1:0]    dbc_cnt;
  logic                btn_stable;
  logic                dbc_done;
  logic [LANE_W-1:0]   lane_idx;
  logic                lane_valid;

  assign btn_stable = (btn == snap);
  assign dbc_done   = (dbc_cnt == DBC_LAST);

  // Lowest overlapping lane of the mask that was classified as a hit
  lane_prio_enc #(
    .N (N_LANES),
    .W (LANE_W)
  ) u_prio (
    .req   (eval_mask),
    .idx   (lane_idx),
    .valid (lane_valid)
  );

  // Controller state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_DETECTING;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. enable only gates the start of a press; a press
  // already being debounced runs to completion regardless.
  always_comb begin
    state_next = state;
    case (state)
      S_DETECTING: begin
        if (enable && (|btn)) begin
          state_next = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (!btn_stable) begin
          state_next = S_DETECTING;
        end else if (dbc_done) begin
          state_next = (|(snap & mole)) ? S_DETECTED : S_MISSED;
        end
      end
      S_DETECTED: state_next = S_RELEASE;
      S_MISSED:   state_next = S_RELEASE;
      S_RELEASE: begin
        if (!(|btn)) begin
          state_next = S_DETECTING;
        end
      end
      default: state_next = S_DETECTING;
    endcase
  end

  // Press snapshot, debounce counter and the overlap mask captured on the
  // classifying edge (the only edge on which mole matters)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap      <= '0;
      dbc_cnt   <= '0;
      eval_mask <= '0;
    end else begin
      case (state)
        S_DETECTING: begin
          if (enable && (|btn)) begin
            snap    <= btn;
            dbc_cnt <= '0;
          end
        end
        S_DEBOUNCE: begin
          if (btn_stable) begin
            if (dbc_done) begin
              eval_mask <= snap & mole;
            end else begin
              dbc_cnt <= dbc_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Registered decodes of the state: pulses, hit report and tallies all
  // change one edge after the controller enters DETECTED or MISSED
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift       <= 1'b0;
      need_random <= 1'b0;
      miss        <= 1'b0;
      hit_mask    <= '0;
      hit_lane    <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      shift       <= (state == S_DETECTED);
      need_random <= (state == S_DETECTED);
      miss        <= (state == S_MISSED);

      if ((state == S_DETECTED) && lane_valid) begin
        hit_mask <= eval_mask;
        hit_lane <= lane_idx;
      end

      if (clr) begin
        hit_count  <= '0;
        miss_count <= '0;
      end else begin
        if (state == S_DETECTED) begin
          hit_count <= CNT_W'(sat_inc(MAX_CNT_W'(hit_count), MAX_CNT_W'(CNT_MAX)));
        end
        if (state == S_MISSED) begin
          miss_count <= CNT_W'(sat_inc(MAX_CNT_W'(miss_count), MAX_CNT_W'(CNT_MAX)));
        end
      end
    end
  end

endmodule

// File: tb/tb_hit_detector.sv
// tb_hit_detector
// Self-checking bench for hit_detector. Two instances share all inputs:
// one with 8-bit tallies and one with 2-bit tallies to exercise saturation.
// Directed steps follow the game scenarios, then a randomized section runs
// against a behavioural press model.
module tb_hit_detector;

  localparam int N  = 3;
  localparam int D  = 4;
  localparam int LW = $clog2(N);

  logic          clk;
  logic          rst;
  logic          enable;
  logic          clr;
  logic [N-1:0]  btn;
  logic [N-1:0]  mole;

  logic          shift, need_random, miss;
  logic [N-1:0]  hit_mask;
  logic [LW-1:0] hit_lane;
  logic [7:0]    hit_count, miss_count;

  logic          s_shift, s_need_random, s_miss;
  logic [N-1:0]  s_hit_mask;
  logic [LW-1:0] s_hit_lane;
  logic [1:0]    s_hit_count, s_miss_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_shift_seen = 0;
  int n_miss_seen  = 0;

  // Reference model: tracks a press as "samples since the snapshot",
  // a post-decision lockout, and the outcome waiting to be published
  bit         m_track;
  int         m_after;
  logic [2:0] m_snap;
  bit         m_lock;
  bit         m_grace;
  int         m_pub;
  logic [2:0] m_pub_mask;

  bit         e_shift;
  bit         e_miss;
  logic [2:0] e_mask;
  int         e_lane;
  int         e_hits, e_misses, e_hits_sat, e_misses_sat;

  hit_detector #(.N_LANES(N), .DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clr(clr), .btn(btn), .mole(mole),
    .shift(shift), .need_random(need_random), .miss(miss),
    .hit_mask(hit_mask), .hit_lane(hit_lane),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  hit_detector #(.N_LANES(N), .DEBOUNCE_CYCLES(D), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .enable(enable), .clr(clr), .btn(btn), .mole(mole),
    .shift(s_shift), .need_random(s_need_random), .miss(s_miss),
    .hit_mask(s_hit_mask), .hit_lane(s_hit_lane),
    .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lowestLane(input logic [2:0] mk);
    for (int i = 0; i < N; i++) begin
      if (mk[i]) return i;
    end
    return 0;
  endfunction

  task automatic modelReset();
    m_track = 0; m_after = 0; m_snap = '0; m_lock = 0; m_grace = 0;
    m_pub = 0; m_pub_mask = '0;
    e_shift = 0; e_miss = 0; e_mask = '0; e_lane = 0;
    e_hits = 0; e_misses = 0; e_hits_sat = 0; e_misses_sat = 0;
  endtask

  // One clock edge of the model, using the inputs the DUT sees at that edge
  task automatic modelStep(input logic [2:0] b, input logic [2:0] m,
                           input logic en, input logic c);
    e_shift = (m_pub == 1);
    e_miss  = (m_pub == 2);
    if (m_pub == 1) begin
      e_mask = m_pub_mask;
      e_lane = lowestLane(m_pub_mask);
    end
    if (c) begin
      e_hits = 0; e_misses = 0; e_hits_sat = 0; e_misses_sat = 0;
    end else if (m_pub == 1) begin
      e_hits     = (e_hits < 255) ? e_hits + 1 : 255;
      e_hits_sat = (e_hits_sat < 3) ? e_hits_sat + 1 : 3;
    end else if (m_pub == 2) begin
      e_misses     = (e_misses < 255) ? e_misses + 1 : 255;
      e_misses_sat = (e_misses_sat < 3) ? e_misses_sat + 1 : 3;
    end
    m_pub = 0;

    if (m_grace) begin
      m_grace = 0;
    end else if (m_lock) begin
      if (b == '0) m_lock = 0;
    end else if (m_track) begin
      if (b != m_snap) begin
        m_track = 0;
      end else begin
        m_after++;
        if (m_after == D) begin
          m_track    = 0;
          m_lock     = 1;
          m_grace    = 1;
          m_pub_mask = m_snap & m;
          m_pub      = (|(m_snap & m)) ? 1 : 2;
        end
      end
    end else if (en && (b != '0)) begin
      m_track = 1;
      m_snap  = b;
      m_after = 0;
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic checkOutput();
    checkVal("shift",        32'(shift),        32'(e_shift));
    checkVal("need_random",  32'(need_random),  32'(e_shift));
    checkVal("miss",         32'(miss),         32'(e_miss));
    checkVal("hit_mask",     32'(hit_mask),     32'(e_mask));
    checkVal("hit_lane",     32'(hit_lane),     32'(e_lane));
    checkVal("hit_count",    32'(hit_count),    32'(e_hits));
    checkVal("miss_count",   32'(miss_count),   32'(e_misses));
    checkVal("sat_shift",    32'(s_shift),      32'(e_shift));
    checkVal("sat_nr",       32'(s_need_random),32'(e_shift));
    checkVal("sat_miss",     32'(s_miss),       32'(e_miss));
    checkVal("sat_hit_mask", 32'(s_hit_mask),   32'(e_mask));
    checkVal("sat_hit_lane", 32'(s_hit_lane),   32'(e_lane));
    checkVal("sat_hits",     32'(s_hit_count),  32'(e_hits_sat));
    checkVal("sat_misses",   32'(s_miss_count), 32'(e_misses_sat));
    if (shift === 1'b1) n_shift_seen++;
    if (miss === 1'b1)  n_miss_seen++;
  endtask

  task automatic applyStimulus(input logic [2:0] b, input logic [2:0] m,
                               input logic en, input logic c);
    btn = b; mole = m; enable = en; clr = c;
    @(posedge clk);
    if (!rst) modelStep(b, m, en, c);
    #1;
    checkOutput();
  endtask

  // Reset is raised between edges; outputs must clear without a clock
  task automatic applyReset();
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput();
    checkVal("rst_shift", 32'(shift), 32'd0);
    checkVal("rst_count", 32'(hit_count), 32'd0);
    checkVal("rst_mask",  32'(hit_mask), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput();
  endtask

  initial begin
    rst = 1'b0; enable = 1'b1; clr = 1'b0; btn = '0; mole = '0;
    modelReset();
    #2;
    applyReset();
    for (int i = 0; i < 3; i++) applyStimulus(3'b000, 3'b000, 1'b1, 1'b0);

    // Hit on lane 1: pulse five edges after the sampling edge
    n_shift_seen = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(3'b010, 3'b010, 1'b1, 1'b0);
      checkVal("hit_latency", 32'(shift), (i == 5) ? 32'd1 : 32'd0);
    end
    checkVal("hit_pulses", 32'(n_shift_seen), 32'd1);
    checkVal("hit_lane1",  32'(hit_lane), 32'd1);
    checkVal("hit_mask1",  32'(hit_mask), 32'b010);
    checkVal("hit_count1", 32'(hit_count), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(3'b000, 3'b010, 1'b1, 1'b0);

    // Miss: pressed lane has no target
    n_shift_seen = 0; n_miss_seen = 0;
    for (int i = 0; i < 10; i++) applyStimulus(3'b100, 3'b001, 1'b1, 1'b0);
    checkVal("miss_pulses", 32'(n_miss_seen), 32'd1);
    checkVal("miss_noshift", 32'(n_shift_seen), 32'd0);
    checkVal("miss_count1", 32'(miss_count), 32'd1);
    checkVal("miss_mask_kept", 32'(hit_mask), 32'b010);
    for (int i = 0; i < 3; i++) applyStimulus(3'b000, 3'b001, 1'b1, 1'b0);

    // Bounce: toggling every two cycles never qualifies
    n_shift_seen = 0; n_miss_seen = 0;
    for (int i = 0; i < 20; i++)
      applyStimulus(((i / 2) % 2 == 0) ? 3'b010 : 3'b000, 3'b010, 1'b1, 1'b0);
    checkVal("bounce_pulses", 32'(n_shift_seen + n_miss_seen), 32'd0);
    checkVal("bounce_count",  32'(hit_count), 32'd1);
    for (int i = 0; i < 10; i++) applyStimulus(3'b010, 3'b010, 1'b1, 1'b0);
    checkVal("bounce_then_hit", 32'(n_shift_seen), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(3'b000, 3'b010, 1'b1, 1'b0);

    // Multi-lane with lockout, then one-cycle release and re-press
    n_shift_seen = 0;
    for (int i = 0; i < 30; i++) applyStimulus(3'b110, 3'b110, 1'b1, 1'b0);
    checkVal("multi_pulses", 32'(n_shift_seen), 32'd1);
    checkVal("multi_lane",   32'(hit_lane), 32'd1);
    checkVal("multi_mask",   32'(hit_mask), 32'b110);
    applyStimulus(3'b000, 3'b110, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(3'b110, 3'b110, 1'b1, 1'b0);
    checkVal("repress_pulses", 32'(n_shift_seen), 32'd2);
    for (int i = 0; i < 3; i++) applyStimulus(3'b000, 3'b011, 1'b1, 1'b0);

    // Fifth hit saturates the 2-bit tally
    for (int i = 0; i < 10; i++) applyStimulus(3'b001, 3'b011, 1'b1, 1'b0);
    checkVal("five_hits", 32'(hit_count), 32'd5);
    checkVal("sat_three", 32'(s_hit_count), 32'd3);
    checkVal("lane0",     32'(hit_lane), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(3'b000, 3'b011, 1'b1, 1'b0);

    // Clear coinciding with a hit increment
    for (int i = 0; i < 10; i++) applyStimulus(3'b001, 3'b001, 1'b1, (i == 5));
    checkVal("clr_wins",     32'(hit_count), 32'd0);
    checkVal("clr_wins_sat", 32'(s_hit_count), 32'd0);
    checkVal("clr_misses",   32'(miss_count), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(3'b000, 3'b001, 1'b0, 1'b0);

    // Disabled detector ignores presses
    n_shift_seen = 0; n_miss_seen = 0;
    for (int i = 0; i < 10; i++) applyStimulus(3'b010, 3'b010, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(3'b000, 3'b010, 1'b0, 1'b0);
    checkVal("disabled", 32'(n_shift_seen + n_miss_seen), 32'd0);

    // Reset during debounce, then a clean press with the button still held
    for (int i = 0; i < 2; i++) applyStimulus(3'b010, 3'b010, 1'b1, 1'b0);
    applyReset();
    n_shift_seen = 0;
    for (int i = 0; i < 8; i++) applyStimulus(3'b010, 3'b010, 1'b1, 1'b0);
    checkVal("post_rst_hit", 32'(hit_count), 32'd1);
    // Reset while locked out in release
    applyReset();
    for (int i = 0; i < 10; i++) applyStimulus(3'b010, 3'b010, 1'b1, 1'b0);
    checkVal("post_rst2_hits", 32'(n_shift_seen), 32'd2);
    for (int i = 0; i < 3; i++) applyStimulus(3'b000, 3'b000, 1'b1, 1'b0);

    // Randomized presses, target flags changing every cycle
    for (int seg = 0; seg < 220; seg++) begin
      logic [2:0] b;
      int len;
      b   = 3'($urandom_range(0, 7));
      len = $urandom_range(1, 12);
      if ($urandom_range(0, 49) == 0) applyReset();
      for (int k = 0; k < len; k++)
        applyStimulus(b, 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 7) != 0), ($urandom_range(0, 31) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
